// File: rtl/alu_add_seq.sv
// Multi-cycle add/sub: one SLICE-bit carry-lookahead slice reused over WIDTH bits, LSB first.
// Optional early termination on trivial upper slices: define ALU_ADD_SEQ_EARLY_EXIT_EN.
module alu_add_seq #(
   parameter int WIDTH = 64,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);
   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_a, r_b, r_sum;
   logic             r_cout, r_ovf, r_out_valid, r_busy, r_in_ready;

   logic [SLICE-1:0] w_a_sl, w_b_sl, w_s_sl;
   logic             w_co;
   logic [WIDTH-1:0] w_sum_nxt;
   logic             w_last;

   function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
      logic [3:0] g, p;
      logic [4:0] c;
      g = a & b;
      p = a ^ b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      return {c[4], p ^ c[3:0]};
   endfunction

   assign w_a_sl = r_a[r_cnt*SLICE +: SLICE];
   assign w_b_sl = r_b[r_cnt*SLICE +: SLICE];

   // 4-bit lookahead groups rippled together inside the slice
   always_comb begin
      logic       c;
      logic [4:0] r;
      c      = r_carry;
      w_s_sl = '0;
      for (int g = 0; g < SLICE/4; g++) begin
         r = cla4(w_a_sl[g*4 +: 4], w_b_sl[g*4 +: 4], c);
         w_s_sl[g*4 +: 4] = r[3:0];
         c = r[4];
      end
      w_co = c;
   end

   always_comb begin
      w_sum_nxt = r_sum;
      w_sum_nxt[r_cnt*SLICE +: SLICE] = w_s_sl;
   end

   assign w_last = (r_cnt == CW'(N-1));

`ifdef ALU_ADD_SEQ_EARLY_EXIT_EN
   logic [WIDTH-1:0] w_lo_mask;
   logic             w_early;
   always_comb begin
      w_lo_mask = '0;
      for (int i = 0; i < N; i++)
         if (CW'(i) <= r_cnt) w_lo_mask[i*SLICE +: SLICE] = {SLICE{1'b1}};
   end
   assign w_early = !w_last && !w_co && (((r_a | r_b) & ~w_lo_mask) == '0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_carry     <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_in_ready  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_in_ready <= 1'b1;
               if (in_valid && r_in_ready) begin
                  r_a        <= op_a;
                  r_b        <= sub ? ~op_b : op_b;
                  r_carry    <= sub;
                  r_cnt      <= '0;
                  r_state    <= RUN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            RUN: begin
               r_sum   <= w_sum_nxt;
               r_carry <= w_co;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_cout      <= w_co;
                  r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum_nxt[WIDTH-1] != r_a[WIDTH-1]);
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
`ifdef ALU_ADD_SEQ_EARLY_EXIT_EN
               else if (w_early) begin
                  r_sum       <= w_sum_nxt & w_lo_mask;
                  r_cout      <= 1'b0;
                  r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                 ((w_sum_nxt[WIDTH-1] & w_lo_mask[WIDTH-1]) != r_a[WIDTH-1]);
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
`endif
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
endmodule

// File: tb/tb_alu_add_seq.sv
// Directed bench for alu_add_seq (WIDTH=64, SLICE=4); expected values hand-computed.
module tb_alu_add_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [63:0] op_a = '0, op_b = '0;
   logic        sub = 1'b0;
   logic        out_valid, out_ready = 1'b0;
   logic [63:0] sum;
   logic        cout, ovf, busy;

   int n_chk = 0;
   int n_fail = 0;

`ifdef ALU_ADD_SEQ_EARLY_EXIT_EN
   localparam int LAT_3P4 = 1;
   localparam int LAT_BIG = 5;
`else
   localparam int LAT_3P4 = 16;
   localparam int LAT_BIG = 16;
`endif

   alu_add_seq #(.WIDTH(64), .SLICE(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present an op and wait for it to be accepted; returns with the accept edge just past.
   task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic s);
      int t = 0;
      while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
      chk("accept_wait", 64'(in_ready), 64'd1);
      op_a = a; op_b = b; sub = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int lat);
      int cyc = 0;
      while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
      chk({tag, "_lat"}, 64'(cyc), 64'(lat));
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("rel_ovalid", 64'(out_valid), 64'd0);
      chk("rel_inready", 64'(in_ready), 64'd1);
      chk("rel_busy", 64'(busy), 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b, input logic s,
                         input int lat, input logic [63:0] es, input logic ec, input logic eo);
      start_op(a, b, s);
      wait_done(tag, lat);
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, 64'(cout), 64'(ec));
      chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
      release_out();
   endtask

   initial begin
      logic [63:0] held;
      #12;
      chk("rst_sum", sum, 64'd0);
      chk("rst_ovalid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_inready", 64'(in_ready), 64'd1);

      run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 16, 64'd0, 1'b1, 1'b0);
      run_op("sub_neg", 64'd5, 64'd7, 1'b1, 16, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      run_op("sub_pos", 64'd7, 64'd5, 1'b1, 16, 64'd2, 1'b1, 1'b0);
      run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 16, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
      run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 16, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
      run_op("add_mix", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3211, 1'b0, 16, 64'd0, 1'b1, 1'b0);

      // Hold in DONE while pulsing in_valid with a different op
      start_op(64'h1234, 64'h1111, 1'b0);
      chk("run_busy", 64'(busy), 64'd1);
      wait_done("hold", 16);
      held = sum;
      chk("hold_sum0", held, 64'h2345);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0]; op_a = 64'hDEAD; op_b = 64'hBEEF; sub = 1'b1;
         @(posedge clk); #1;
         chk("hold_inready", 64'(in_ready), 64'd0);
         chk("hold_ovalid", 64'(out_valid), 64'd1);
         chk("hold_sum", sum, 64'h2345);
         chk("hold_flags", {62'd0, cout, ovf}, 64'd0);
      end
      in_valid = 1'b0;
      release_out();
      chk("idle_sum_kept", sum, 64'h2345);

      // Reset mid-operation
      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_sum", sum, 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_ovalid", 64'(out_valid), 64'd0);
      chk("arst_flags", {62'd0, cout, ovf}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("arst_inready", 64'(in_ready), 64'd1);
      run_op("post_rst", 64'd3, 64'd4, 1'b0, LAT_3P4, 64'd7, 1'b0, 1'b0);
      run_op("big_early", 64'h1_0000, 64'd1, 1'b0, LAT_BIG, 64'h1_0001, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
